// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between execute, the memory-stage sequencer, the data bus and writeback.
// The master modport is the sequencer's view; slave is the surrounding pipeline/bus.
interface mem_access_ctrl_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [63:0] ex_result;
    logic [4:0]  ex_rd;
    logic        flush;

    logic        dreq_valid;
    logic        dreq_ready;
    logic        dreq_write;
    logic [63:0] dreq_addr;
    logic [63:0] dreq_data;
    logic [7:0]  dreq_strobe;
    logic        dresp_valid;
    logic [63:0] dresp_data;

    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [1:0]  wb_err;

    modport master (
        input  ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata, ex_result, ex_rd, flush,
        input  dreq_ready, dresp_valid, dresp_data,
        output ex_ready,
        output dreq_valid, dreq_write, dreq_addr, dreq_data, dreq_strobe,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport slave (
        output ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata, ex_result, ex_rd, flush,
        output dreq_ready, dresp_valid, dresp_data,
        input  ex_ready,
        input  dreq_valid, dreq_write, dreq_addr, dreq_data, dreq_strobe,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// RV64 memory-stage sequencer: one instruction at a time, LD/SD over a req/resp bus
// with misalignment and response-timeout detection, single-cycle writeback pulse.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    mem_access_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state, state_nxt;
    logic [63:0] addr_q, wdata_q, wb_data_q;
    logic [4:0]  rd_q;
    logic        is_store_q, kill_q, kill_nxt, wb_we_q;
    logic [1:0]  wb_err_q;
    logic [15:0] cnt_q;
    logic        accept, is_mem, misaligned, timed_out;

    assign bus.ex_ready = (state == IDLE);
    assign accept       = bus.ex_valid && bus.ex_ready;
    assign is_mem       = bus.ex_is_load || bus.ex_is_store;
    assign misaligned   = (bus.ex_addr[2:0] != 3'd0);
    assign timed_out    = (cnt_q == TIMEOUT_CNT);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (is_mem && !misaligned) ? REQ : DONE;
            // Once the bus has taken the request the handshake must finish; before that a kill abandons it.
            REQ:  if (bus.dreq_ready) state_nxt = WAIT;
                  else if (bus.flush || kill_q) state_nxt = IDLE;
            WAIT: if (bus.dresp_valid || timed_out) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        kill_nxt = kill_q;
        if (state_nxt == IDLE)  kill_nxt = 1'b0;
        else if (state == IDLE) kill_nxt = accept && bus.flush;
        else                    kill_nxt = kill_q || bus.flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state  <= IDLE;
            kill_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            kill_q <= kill_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            cnt_q      <= '0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= '0;
            wb_err_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_q     <= bus.ex_addr;
                    wdata_q    <= bus.ex_wdata;
                    rd_q       <= bus.ex_rd;
                    is_store_q <= bus.ex_is_store;
                    if (!is_mem) begin
                        wb_we_q   <= (bus.ex_rd != 5'd0);
                        wb_data_q <= bus.ex_result;
                        wb_err_q  <= 2'd0;
                    end else if (misaligned) begin
                        wb_we_q   <= 1'b0;
                        wb_data_q <= '0;
                        wb_err_q  <= 2'd1;
                    end
                end
                REQ: if (bus.dreq_ready) cnt_q <= '0;
                WAIT: begin
                    if (bus.dresp_valid) begin
                        wb_we_q   <= !is_store_q && (rd_q != 5'd0);
                        wb_data_q <= is_store_q ? 64'd0 : bus.dresp_data;
                        wb_err_q  <= 2'd0;
                    end else if (timed_out) begin
                        wb_we_q   <= 1'b0;
                        wb_data_q <= '0;
                        wb_err_q  <= 2'd2;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dreq_valid  = (state == REQ);
    assign bus.dreq_write  = bus.dreq_valid && is_store_q;
    assign bus.dreq_addr   = bus.dreq_valid ? addr_q : 64'd0;
    assign bus.dreq_data   = bus.dreq_write ? wdata_q : 64'd0;
    assign bus.dreq_strobe = bus.dreq_write ? 8'hFF : 8'h00;

    // A flush arriving during DONE itself still suppresses the pulse.
    assign bus.wb_valid = (state == DONE) && !kill_q && !bus.flush;
    assign bus.wb_we    = bus.wb_valid && wb_we_q;
    assign bus.wb_rd    = bus.wb_valid ? rd_q : 5'd0;
    assign bus.wb_data  = bus.wb_valid ? wb_data_q : 64'd0;
    assign bus.wb_err   = bus.wb_valid ? wb_err_q : 2'd0;
endmodule
